// File: rtl/room_map_gen.sv
// room_map_gen: registered per-pixel room-map colour with four animated doorways.
// Each side has a sliding door whose opening width advances one STEP every
// ANIM_FRAMES video frames, under single-cycle open/close request control.
module room_map_gen #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned WALL_T      = 40,
  parameter int unsigned DOOR_W      = 120,
  parameter int unsigned STEP        = 8,
  parameter int unsigned ANIM_FRAMES = 2,
  parameter logic [7:0]  FLOOR       = 8'hB6,
  parameter logic [7:0]  DOOR_COLOR  = 8'h8C
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic [9:0] CurrentX,
  input  logic [8:0] CurrentY,
  input  logic [7:0] wall,
  input  logic [3:0] door_mask,
  input  logic [3:0] open_req,
  input  logic [3:0] close_req,
  output logic [7:0] mapData,
  output logic [3:0] door_open,
  output logic [3:0] door_busy
);

  localparam int unsigned WW = $clog2(DOOR_W + 1);
  localparam int unsigned PW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int unsigned CW = 11;

  localparam logic [CW-1:0] TOP_END     = CW'(WALL_T);
  localparam logic [CW-1:0] BOT_START   = CW'(V_RES - WALL_T);
  localparam logic [CW-1:0] LEFT_END    = CW'(WALL_T);
  localparam logic [CW-1:0] RIGHT_START = CW'(H_RES - WALL_T);
  localparam logic [CW-1:0] D0_NS       = CW'(H_RES / 2 - DOOR_W / 2);
  localparam logic [CW-1:0] D0_EW       = CW'(V_RES / 2 - DOOR_W / 2);
  localparam logic [CW-1:0] DW_C        = CW'(DOOR_W);
  localparam logic [WW-1:0] W_MAX       = WW'(DOOR_W);
  localparam logic [WW-1:0] W_STEP      = WW'(STEP);
  localparam logic [PW-1:0] PRE_LAST    = PW'(ANIM_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } door_st_e;

  // Frame detection and animation prescaler
  logic [9:0]    prev_x_q;
  logic [8:0]    prev_y_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          frame_tick_c;
  logic          anim_step_c;

  // Door state per side (0 N, 1 E, 2 S, 3 W)
  door_st_e      state_q [4];
  door_st_e      state_d [4];
  logic [WW-1:0] w_q     [4];
  logic [WW-1:0] w_d     [4];
  logic [3:0]    open_q, open_d;
  logic [3:0]    busy_q, busy_d;

  // Pixel path
  logic [CW-1:0] x_c, y_c;
  logic          in_top_c, in_bot_c, in_left_c, in_right_c;
  logic [2:0]    bands_c;
  logic          ns_span_c, ew_span_c;
  logic [7:0]    pix_c;
  logic [7:0]    map_q;

  assign mapData   = map_q;
  assign door_open = open_q;
  assign door_busy = busy_q;

  // Frame tick: arrival at the origin from any other position
  assign frame_tick_c = (CurrentX == 10'd0) && (CurrentY == 9'd0) &&
                        !((prev_x_q == 10'd0) && (prev_y_q == 9'd0));

  // Prescaler: one anim step every ANIM_FRAMES ticks
  always_comb begin
    pre_d       = pre_q;
    anim_step_c = 1'b0;
    if (frame_tick_c) begin
      if (pre_q == PRE_LAST) begin
        pre_d       = '0;
        anim_step_c = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Door FSM next-state: request transition first, then the step on the new state
  always_comb begin
    open_d = '0;
    busy_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      w_d[i]     = w_q[i];
      if (!door_mask[i]) begin
        state_d[i] = ST_CLOSED;
        w_d[i]     = '0;
      end else begin
        if (open_req[i] && !close_req[i] &&
            (state_q[i] == ST_CLOSED || state_q[i] == ST_CLOSING)) begin
          state_d[i] = ST_OPENING;
        end
        if (close_req[i] && !open_req[i] &&
            (state_q[i] == ST_OPEN || state_q[i] == ST_OPENING)) begin
          state_d[i] = ST_CLOSING;
        end
        if (anim_step_c) begin
          if (state_d[i] == ST_OPENING) begin
            if (w_q[i] >= W_MAX - W_STEP) begin
              w_d[i]     = W_MAX;
              state_d[i] = ST_OPEN;
            end else begin
              w_d[i] = w_q[i] + W_STEP;
            end
          end else if (state_d[i] == ST_CLOSING) begin
            if (w_q[i] <= W_STEP) begin
              w_d[i]     = '0;
              state_d[i] = ST_CLOSED;
            end else begin
              w_d[i] = w_q[i] - W_STEP;
            end
          end
        end
      end
      open_d[i] = (state_d[i] == ST_OPEN);
      busy_d[i] = (state_d[i] == ST_OPENING) || (state_d[i] == ST_CLOSING);
    end
  end

  // Band and doorway-span decode on the zero-extended scan position
  assign x_c        = CW'(CurrentX);
  assign y_c        = CW'(CurrentY);
  assign in_top_c   = y_c < TOP_END;
  assign in_bot_c   = y_c >= BOT_START;
  assign in_left_c  = x_c < LEFT_END;
  assign in_right_c = x_c >= RIGHT_START;
  assign bands_c    = 3'(in_top_c) + 3'(in_bot_c) + 3'(in_left_c) + 3'(in_right_c);
  assign ns_span_c  = (x_c >= D0_NS) && (x_c < D0_NS + DW_C);
  assign ew_span_c  = (y_c >= D0_EW) && (y_c < D0_EW + DW_C);

  // Pixel colour priority: corner, open gap, door leaf, wall band, floor
  always_comb begin
    pix_c = FLOOR;
    if (bands_c >= 3'd2) begin
      pix_c = wall;
    end else if (in_top_c && ns_span_c && door_mask[0]) begin
      pix_c = (x_c < D0_NS + CW'(w_q[0])) ? FLOOR : DOOR_COLOR;
    end else if (in_right_c && ew_span_c && door_mask[1]) begin
      pix_c = (y_c < D0_EW + CW'(w_q[1])) ? FLOOR : DOOR_COLOR;
    end else if (in_bot_c && ns_span_c && door_mask[2]) begin
      pix_c = (x_c < D0_NS + CW'(w_q[2])) ? FLOOR : DOOR_COLOR;
    end else if (in_left_c && ew_span_c && door_mask[3]) begin
      pix_c = (y_c < D0_EW + CW'(w_q[3])) ? FLOOR : DOOR_COLOR;
    end else if (bands_c != 3'd0) begin
      pix_c = wall;
    end
  end

  // State, prescaler and output registers
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      prev_x_q <= '0;
      prev_y_q <= '0;
      pre_q    <= '0;
      map_q    <= 8'h00;
      open_q   <= '0;
      busy_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_CLOSED;
        w_q[i]     <= '0;
      end
    end else begin
      prev_x_q <= CurrentX;
      prev_y_q <= CurrentY;
      pre_q    <= pre_d;
      map_q    <= pix_c;
      open_q   <= open_d;
      busy_q   <= busy_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        w_q[i]     <= w_d[i];
      end
    end
  end

endmodule

// File: tb/tb_room_map_gen.sv
// tb_room_map_gen: directed plan steps plus random scan/request traffic,
// checked every cycle against a target/width door model and a rule-based pixel function.
module tb_room_map_gen;

  localparam int HR = 640;
  localparam int VR = 480;
  localparam int WT = 40;
  localparam int DW = 120;
  localparam int ST = 8;
  localparam int AF = 2;
  localparam logic [7:0] FLR  = 8'hB6;
  localparam logic [7:0] DCOL = 8'h8C;

  logic       clk_vga = 1'b0;
  logic       rst_n;
  logic [9:0] CurrentX;
  logic [8:0] CurrentY;
  logic [7:0] wall;
  logic [3:0] door_mask;
  logic [3:0] open_req;
  logic [3:0] close_req;
  logic [7:0] mapData;
  logic [3:0] door_open;
  logic [3:0] door_busy;

  int nchk = 0;
  int nerr = 0;

  // Model: per side, opening width, whether the door is aimed open, and whether it is moving
  int mw   [4];
  bit mtgt [4];
  bit mmov [4];
  int mticks;
  int px, py;

  room_map_gen #(
    .H_RES(HR), .V_RES(VR), .WALL_T(WT), .DOOR_W(DW), .STEP(ST),
    .ANIM_FRAMES(AF), .FLOOR(FLR), .DOOR_COLOR(DCOL)
  ) dut (
    .clk_vga   (clk_vga),
    .rst_n     (rst_n),
    .CurrentX  (CurrentX),
    .CurrentY  (CurrentY),
    .wall      (wall),
    .door_mask (door_mask),
    .open_req  (open_req),
    .close_req (close_req),
    .mapData   (mapData),
    .door_open (door_open),
    .door_busy (door_busy)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 0; mtgt[i] = 1'b0; mmov[i] = 1'b0;
    end
    mticks = 0; px = 0; py = 0;
  endtask

  // Colour from the room rules using the model's widths
  function automatic logic [7:0] ref_pix(int x, int y, logic [3:0] m, logic [7:0] wc);
    int t, b, l, r, side, pos;
    t = (y < WT) ? 1 : 0;
    b = (y >= VR - WT) ? 1 : 0;
    l = (x < WT) ? 1 : 0;
    r = (x >= HR - WT) ? 1 : 0;
    if (t + b + l + r >= 2) return wc;
    if (t + b + l + r == 0) return FLR;
    side = (t == 1) ? 0 : (r == 1) ? 1 : (b == 1) ? 2 : 3;
    pos  = (side == 0 || side == 2) ? x - (HR / 2 - DW / 2) : y - (VR / 2 - DW / 2);
    if (m[side] && pos >= 0 && pos < DW) return (pos < mw[side]) ? FLR : DCOL;
    return wc;
  endfunction

  // One clock: drive at negedge, advance model at posedge, check just after
  task automatic cyc(input int x, input int y, input logic [3:0] orq, input logic [3:0] crq);
    logic [7:0] exp_pix;
    logic [3:0] eo, eb;
    bit tick, stp;
    @(negedge clk_vga);
    CurrentX  = 10'(x);
    CurrentY  = 9'(y);
    open_req  = orq;
    close_req = crq;
    @(posedge clk_vga);
    exp_pix = ref_pix(x, y, door_mask, wall);
    tick = (x == 0 && y == 0) && !(px == 0 && py == 0);
    px = x; py = y;
    stp = 1'b0;
    if (tick) begin
      mticks++;
      if (mticks % AF == 0) stp = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (!door_mask[i]) begin
        mtgt[i] = 1'b0; mmov[i] = 1'b0; mw[i] = 0;
      end else begin
        if (orq[i] && !crq[i] && !mtgt[i]) begin mtgt[i] = 1'b1; mmov[i] = 1'b1; end
        else if (crq[i] && !orq[i] && mtgt[i]) begin mtgt[i] = 1'b0; mmov[i] = 1'b1; end
        if (stp && mmov[i]) begin
          if (mtgt[i]) mw[i] = (mw[i] + ST > DW) ? DW : mw[i] + ST;
          else         mw[i] = (mw[i] < ST) ? 0 : mw[i] - ST;
          if (mw[i] == (mtgt[i] ? DW : 0)) mmov[i] = 1'b0;
        end
      end
      eo[i] = mtgt[i] && !mmov[i];
      eb[i] = mmov[i];
    end
    #1;
    chk("mapData", 32'(mapData), 32'(exp_pix));
    chk("door_open", 32'(door_open), 32'(eo));
    chk("door_busy", 32'(door_busy), 32'(eb));
    open_req  = '0;
    close_req = '0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(5, 5, 4'b0000, 4'b0000);
      cyc(0, 0, 4'b0000, 4'b0000);
    end
  endtask

  task automatic probe(input int x, input int y, input logic [7:0] lit, input string tag);
    cyc(x, y, 4'b0000, 4'b0000);
    chk(tag, 32'(mapData), 32'(lit));
  endtask

  initial begin
    int rx, ry, sel;
    logic [3:0] orq, crq;
    rst_n = 1'b0; CurrentX = '0; CurrentY = '0; wall = 8'h11;
    door_mask = '0; open_req = '0; close_req = '0;
    model_reset();
    repeat (3) @(posedge clk_vga);
    #1;
    chk("reset mapData", 32'(mapData), 32'h00);
    chk("reset door_open", 32'(door_open), 32'h0);
    chk("reset door_busy", 32'(door_busy), 32'h0);
    rst_n = 1'b1;

    // Static map with only the north door enabled
    door_mask = 4'b0001;
    probe(100, 10, 8'h11, "n wall");
    probe(300, 10, 8'h8C, "n leaf closed");
    probe(300, 460, 8'h11, "s masked");
    probe(300, 200, 8'hB6, "floor");
    probe(5, 5, 8'h11, "corner");

    // North door opens: 4 steps after 8 frames, open after 30
    cyc(5, 5, 4'b0001, 4'b0000);
    frames(8);
    probe(291, 10, 8'hB6, "n gap w32");
    probe(292, 10, 8'h8C, "n leaf w32");
    chk("busy0 opening", 32'(door_busy[0]), 32'h1);
    frames(22);
    chk("open0 full", 32'(door_open[0]), 32'h1);
    probe(379, 10, 8'hB6, "n gap full");

    // East door reversal at w=64
    door_mask = 4'b0011;
    cyc(5, 5, 4'b0010, 4'b0000);
    frames(16);
    cyc(5, 5, 4'b0000, 4'b0010);
    chk("busy1 closing", 32'(door_busy[1]), 32'h1);
    frames(16);
    chk("busy1 done", 32'(door_busy[1]), 32'h0);
    probe(620, 180, 8'h8C, "e leaf closed");

    // Conflicting requests and requests on a masked side are ignored
    door_mask = 4'b0111;
    cyc(5, 5, 4'b0100, 4'b0100);
    frames(4);
    chk("busy2 conflict", 32'(door_busy[2]), 32'h0);
    probe(300, 460, 8'h8C, "s leaf closed");
    cyc(5, 5, 4'b1000, 4'b0000);
    frames(4);
    chk("busy3 masked", 32'(door_busy[3]), 32'h0);
    probe(10, 200, 8'h11, "w masked");

    // Mask drop while opening at w=48
    door_mask = 4'b0110;
    cyc(5, 5, 4'b0000, 4'b0000);
    door_mask = 4'b0111;
    cyc(5, 5, 4'b0001, 4'b0000);
    frames(12);
    probe(307, 10, 8'hB6, "n gap w48");
    probe(308, 10, 8'h8C, "n leaf w48");
    door_mask = 4'b0110;
    probe(300, 10, 8'h11, "mask drop pix");
    chk("busy0 mask drop", 32'(door_busy[0]), 32'h0);
    probe(300, 10, 8'h11, "mask drop next");
    door_mask = 4'b0111;
    probe(300, 10, 8'h8C, "reenabled closed");

    // Asynchronous reset during an opening
    cyc(5, 5, 4'b0001, 4'b0000);
    frames(6);
    chk("busy0 before reset", 32'(door_busy[0]), 32'h1);
    @(negedge clk_vga);
    #2 rst_n = 1'b0;
    #1;
    chk("async mapData", 32'(mapData), 32'h00);
    chk("async door_open", 32'(door_open), 32'h0);
    chk("async door_busy", 32'(door_busy), 32'h0);
    model_reset();
    @(posedge clk_vga);
    #1 rst_n = 1'b1;
    probe(300, 10, 8'h8C, "post reset closed");
    probe(300, 200, 8'hB6, "post reset floor");

    // Random scan positions, requests, masks and wall colours
    door_mask = 4'hF;
    for (int n = 0; n < 2500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2) begin
        rx = 0; ry = 0;
      end else if (sel <= 5) begin
        rx = $urandom_range(250, 390);
        ry = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 45) : $urandom_range(430, 479);
      end else if (sel <= 7) begin
        rx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 45) : $urandom_range(595, 639);
        ry = $urandom_range(170, 310);
      end else begin
        rx = $urandom_range(0, HR - 1);
        ry = $urandom_range(0, VR - 1);
      end
      orq = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      crq = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      cyc(rx, ry, orq, crq);
      if ($urandom_range(0, 149) == 0) door_mask = 4'($urandom);
      if ($urandom_range(0, 99) == 0) wall = 8'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/room_map_gen.md
# room_map_gen

Parametrised room-map pixel generator for the VGA game renderer. It registers one 8-bit map colour per pixel from the scan position. The room has walls on four sides, and each side has an optional centred doorway. Each door slides open or closed under request control, advancing one step every few video frames. It replaces the fixed per-room map modules and feeds the same mapData path into the sprite/colour mux.

## Interface
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.
- WALL_T, 40: wall thickness in pixels, all four sides.
- DOOR_W, 120: doorway length in pixels. Must satisfy DOOR_W <= V_RES-2*WALL_T.
- STEP, 8: pixels a door moves per animation step. DOOR_W must be a multiple of STEP.
- ANIM_FRAMES, 2: frames per animation step (>=1).
- FLOOR, 8'hB6: floor colour.
- DOOR_COLOR, 8'h8C: colour of the closed part of an enabled door.
- clk_vga  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- CurrentX  in  10  scan column.
- CurrentY  in  9  scan row.
- wall  in  8  wall colour.
- door_mask  in  4  per-side door enable: bit0 N, bit1 E, bit2 S, bit3 W.
- open_req  in  4  per-side open request, single-cycle pulse.
- close_req  in  4  per-side close request, single-cycle pulse.
- mapData  out  8  registered pixel colour.
- door_open  out  4  side fully open (state OPEN).
- door_busy  out  4  side in OPENING or CLOSING.

## Operation
- Bands:
  - top: Y<WALL_T
  - bottom: Y>=V_RES-WALL_T
  - left: X<WALL_T
  - right: X>=H_RES-WALL_T
- Doorway span along its wall, starting at D0:
  - N/S: D0 = H_RES/2-DOOR_W/2. Defaults give X 260..379.
  - E/W: D0 = V_RES/2-DOOR_W/2. Defaults give Y 180..299.
- Per-side opening width w, range 0..DOOR_W. The open gap is [D0, D0+w). The remainder [D0+w, D0+DOOR_W) is the door leaf.
- Pixel colour, first match wins:
  1. Pixel in two bands (corner) -> wall.
  2. Pixel in a band, inside that side's doorway span, door_mask set, inside the gap -> FLOOR.
  3. Same, but in the leaf -> DOOR_COLOR.
  4. Any band -> wall.
  5. Otherwise -> FLOOR.
- Frame tick: one-cycle pulse when (CurrentX,CurrentY)==(0,0) and the previous cycle's position was not (0,0).
- Prescaler 0..ANIM_FRAMES-1, advanced on each frame tick. An anim_step pulse fires on the tick where the prescaler equals ANIM_FRAMES-1, and the prescaler wraps to 0.
- Per-side FSM states: CLOSED, OPENING, OPEN, CLOSING.
  - open_req in CLOSED or CLOSING -> OPENING.
  - close_req in OPEN or OPENING -> CLOSING.
  - open_req and close_req on the same side in the same cycle -> ignored.
  - Requests on a side with door_mask clear -> ignored.
  - Requests that are redundant for the current state -> ignored.
  - door_mask bit cleared -> that side goes to CLOSED with w=0 on the next edge, regardless of state.
  - On anim_step, OPENING: w = min(w+STEP, DOOR_W). Enter OPEN when w reaches DOOR_W.
  - On anim_step, CLOSING: w = max(w-STEP, 0). Enter CLOSED when w reaches 0.
  - Reversal mid-motion keeps the current w.
  - Request and anim_step in the same cycle: the state transition applies first, then the step uses the new state.
- Width of w is $clog2(DOOR_W+1). Comparisons are unsigned, with X/Y zero-extended.

## Timing
- mapData has 1-cycle latency: the colour for the (X,Y) sampled at edge n appears after edge n.
- mapData changes only on rising clk_vga.
- Pixel lookup uses w and door_mask as registered before the same edge.
- A request at edge n:
  - state visible at edge n;
  - door_busy high from edge n;
  - pixel effect from the next anim_step.
- From CLOSED, OPEN is reached after DOOR_W/STEP steps: 15 steps, 30 frames at defaults.
- Reset values (asynchronous, immediate):
  - mapData 8'h00, door_open 0, door_busy 0;
  - all w 0, all states CLOSED, prescaler 0, previous-position register (0,0).
- The first (0,0) after reset produces no tick.
- Reset deasserting mid-frame resumes normally. Reset mid-motion leaves all doors closed.

## Test plan
- Reset with rst_n=0 mid-scan: mapData 8'h00 and door_open/busy 0 within the same cycle, with no clock edge needed.
- door_mask=4'b0001, all doors CLOSED, wall=8'h11. Expected next-cycle mapData:
  - (100,10) -> 8'h11
  - (300,10) -> 8'h8C
  - (300,460) -> 8'h11 (S door masked)
  - (300,200) -> 8'hB6
  - (5,5) -> 8'h11
- Pulse open_req[0] and run 8 frames (4 steps, w=32):
  - (291,10) -> 8'hB6, (292,10) -> 8'h8C, door_busy[0]=1.
  - After 30 frames total: door_open[0]=1 and (379,10) -> 8'hB6.
- Reversal: close_req[1] at w=64 while OPENING, then 16 more frames -> door_busy[1]=0, (620,180) -> 8'h8C.
- Same-cycle open_req[2] and close_req[2], or open_req[3] with door_mask[3]=0 -> no state change over 4 frames.
- Mask drop while door 0 is OPENING at w=48 -> next cycle CLOSED with w=0 and (300,10) -> wall. Separately, an async reset mid-OPENING leaves all doors CLOSED.
